melody_sequencer: RTL and testbench



---
 rtl/melody_sequencer_pkg.sv | 51 +++++
 rtl/melody_rom.sv | 48 ++++
 rtl/melody_sequencer.sv | 132 +++++++++++++
 tb/tb_melody_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: note codes, 40 MHz half-period
// divide table, default divider width and FSM state encoding.
package melody_sequencer_pkg;

    localparam int DIV_WIDTH_DEF = 20;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_CS4  = 4'd2;
    localparam logic [3:0] NOTE_D4   = 4'd3;
    localparam logic [3:0] NOTE_DS4  = 4'd4;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_F4   = 4'd6;
    localparam logic [3:0] NOTE_FS4  = 4'd7;
    localparam logic [3:0] NOTE_G4   = 4'd8;
    localparam logic [3:0] NOTE_GS4  = 4'd9;
    localparam logic [3:0] NOTE_A4   = 4'd10;
    localparam logic [3:0] NOTE_AS4  = 4'd11;
    localparam logic [3:0] NOTE_B4   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // round(20 MHz / f): half-period counts at a 40 MHz system clock
    function automatic logic [19:0] note_half_period(input logic [3:0] code);
        case (code)
            NOTE_C4:  return 20'd76336;
            NOTE_CS4: return 20'd72202;
            NOTE_D4:  return 20'd68027;
            NOTE_DS4: return 20'd64309;
            NOTE_E4:  return 20'd60606;
            NOTE_F4:  return 20'd57307;
            NOTE_FS4: return 20'd54054;
            NOTE_G4:  return 20'd51020;
            NOTE_GS4: return 20'd48193;
            NOTE_A4:  return 20'd45455;
            NOTE_AS4: return 20'd42918;
            NOTE_B4:  return 20'd40486;
            default:  return 20'd0;
        endcase
    endfunction

    function automatic logic is_tone(input logic [3:0] code);
        return (code >= NOTE_C4) && (code <= NOTE_B4);
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Fixed melody ROM: entry = {note_code[3:0], dur[3:0]}, dur 0 marks end of song.
// SONG_ID 0 is the shipping tune; SONG_ID 1 is a short tune with a marker.
module melody_rom
    import melody_sequencer_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int SONG_ID = 0
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       entry
);

    logic [7:0] addr;
    assign addr = 8'(idx);

    always_comb begin
        entry = 8'h00;
        if (SONG_ID == 1) begin
            case (addr)
                8'd0:    entry = {NOTE_A4,   4'd1};
                8'd1:    entry = {NOTE_C4,   4'd2};
                8'd2:    entry = {NOTE_REST, 4'd1};
                default: entry = 8'h00;
            endcase
        end else begin
            case (addr)
                8'd0:    entry = {NOTE_C4,   4'd1};
                8'd1:    entry = {NOTE_D4,   4'd1};
                8'd2:    entry = {NOTE_E4,   4'd1};
                8'd3:    entry = {NOTE_F4,   4'd1};
                8'd4:    entry = {NOTE_G4,   4'd2};
                8'd5:    entry = {NOTE_G4,   4'd2};
                8'd6:    entry = {NOTE_A4,   4'd1};
                8'd7:    entry = {NOTE_A4,   4'd1};
                8'd8:    entry = {NOTE_G4,   4'd2};
                8'd9:    entry = {NOTE_REST, 4'd1};
                8'd10:   entry = {NOTE_F4,   4'd1};
                8'd11:   entry = {NOTE_F4,   4'd1};
                8'd12:   entry = {NOTE_E4,   4'd2};
                8'd13:   entry = {NOTE_D4,   4'd1};
                8'd14:   entry = {NOTE_D4,   4'd1};
                8'd15:   entry = {NOTE_C4,   4'd2};
                default: entry = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through melody_rom on edges of the 100 Hz tick_in and emits tone divide counts.
// Define MELODY_LOOP_EN to wrap to index 0 at song end instead of stopping.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int SONG_LEN   = 16,
    parameter int BEAT_TICKS = 25,
    parameter int GAP_TICKS  = 2,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int SONG_ID    = 0,
    localparam int IDX_W     = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic                 play,
    input  logic                 stop,
    output logic [DIV_WIDTH-1:0] note_div,
    output logic                 note_valid,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     note_idx,
    output logic [1:0]           state_dbg
);

    localparam int MAX_CNT = (15 * BEAT_TICKS > GAP_TICKS) ? 15 * BEAT_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    seq_state_t           state;
    logic                 s1, s2, s3, tick;
    logic [CNT_W-1:0]     tick_cnt, note_last, gap_last;
    logic [7:0]           cur_entry, nxt_entry;
    logic [IDX_W-1:0]     nxt_idx;
    logic [DIV_WIDTH-1:0] nxt_div;
    logic                 nxt_valid, note_end, gap_end, advance, song_end;

    assign tick      = s2 & ~s3;
    assign state_dbg = state;

    assign note_last = CNT_W'(cur_entry[3:0]) * CNT_W'(BEAT_TICKS) - CNT_W'(1);
    assign gap_last  = CNT_W'(GAP_TICKS) - CNT_W'(1);
    assign note_end  = (state == ST_NOTE) && (cur_entry[3:0] != 4'd0) && tick && (tick_cnt == note_last);
    assign gap_end   = (state == ST_GAP) && tick && (tick_cnt == gap_last);
    assign advance   = (GAP_TICKS > 0) ? gap_end : note_end;
    assign song_end  = (advance && (note_idx == LAST_IDX)) ||
                       ((state == ST_NOTE) && (cur_entry[3:0] == 4'd0));

    // Second ROM port looks up the entry being moved to, so outputs change with the index
    assign nxt_idx   = ((state == ST_IDLE) || song_end) ? '0 : note_idx + IDX_W'(1);
    assign nxt_div   = DIV_WIDTH'(note_half_period(nxt_entry[7:4]));
    assign nxt_valid = is_tone(nxt_entry[7:4]);

    melody_rom #(.IDX_W(IDX_W), .SONG_ID(SONG_ID)) u_rom_cur (.idx(note_idx), .entry(cur_entry));
    melody_rom #(.IDX_W(IDX_W), .SONG_ID(SONG_ID)) u_rom_nxt (.idx(nxt_idx),  .entry(nxt_entry));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            note_idx   <= '0;
            note_div   <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            s1   <= tick_in;
            s2   <= s1;
            s3   <= s2;
            done <= 1'b0;
            if (stop) begin
                state      <= ST_IDLE;
                tick_cnt   <= '0;
                note_idx   <= '0;
                note_div   <= '0;
                note_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (play) begin
                            state      <= ST_NOTE;
                            tick_cnt   <= '0;
                            note_idx   <= '0;
                            note_div   <= nxt_div;
                            note_valid <= nxt_valid;
                            busy       <= 1'b1;
                        end
                    end
                    ST_NOTE, ST_GAP: begin
                        if (song_end) begin
                            done     <= 1'b1;
                            tick_cnt <= '0;
`ifdef MELODY_LOOP_EN
                            state      <= ST_NOTE;
                            note_idx   <= '0;
                            note_div   <= nxt_div;
                            note_valid <= nxt_valid;
`else
                            state      <= ST_DONE;
                            note_div   <= '0;
                            note_valid <= 1'b0;
`endif
                        end else if (advance) begin
                            state      <= ST_NOTE;
                            tick_cnt   <= '0;
                            note_idx   <= nxt_idx;
                            note_div   <= nxt_div;
                            note_valid <= nxt_valid;
                        end else if (note_end) begin
                            state      <= ST_GAP;
                            tick_cnt   <= '0;
                            note_div   <= '0;
                            note_valid <= 1'b0;
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        note_idx <= '0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench: dut_a plays the short marker-terminated tune, dut_b the full 16-entry tune.
module tb_melody_sequencer;
    import melody_sequencer_pkg::*;

    localparam int DW    = 20;
    localparam int IW    = 4;
    localparam int TUP_W = DW + 1 + IW + 1 + 1;
    localparam int SEG_W = TUP_W + 8;

    logic clk = 1'b0, rst_n = 1'b0, tick_in = 1'b0, stop = 1'b0;
    logic play_a = 1'b0, play_b = 1'b0;
    logic [DW-1:0] note_div_a, note_div_b;
    logic note_valid_a, note_valid_b, busy_a, busy_b, done_a, done_b;
    logic [IW-1:0] note_idx_a, note_idx_b;
    logic [1:0] state_a, state_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [SEG_W-1:0] exp_q[$];
    logic rec = 1'b0;
    logic tick_last = 1'b0;
    logic [TUP_W-1:0] prev = '0;
    int seg_ticks = 0;

    logic [TUP_W-1:0] tup_a, tup_b;
    assign tup_a = {note_div_a, note_valid_a, note_idx_a, busy_a, done_a};
    assign tup_b = {note_div_b, note_valid_b, note_idx_b, busy_b, done_b};

    melody_sequencer #(.SONG_LEN(16), .BEAT_TICKS(2), .GAP_TICKS(1), .DIV_WIDTH(DW), .SONG_ID(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .play(play_a), .stop(stop),
        .note_div(note_div_a), .note_valid(note_valid_a), .busy(busy_a), .done(done_a),
        .note_idx(note_idx_a), .state_dbg(state_a)
    );

    melody_sequencer #(.SONG_LEN(16), .BEAT_TICKS(2), .GAP_TICKS(1), .DIV_WIDTH(DW), .SONG_ID(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .play(play_b), .stop(stop),
        .note_div(note_div_b), .note_valid(note_valid_b), .busy(busy_b), .done(done_b),
        .note_idx(note_idx_b), .state_dbg(state_b)
    );

    // clock / tick generation: tick_in period is 40 clk, toggling 3 ns after a rising clk
    always #5 clk = ~clk;
    initial begin
        forever begin
            repeat (20) @(posedge clk);
            #3 tick_in = ~tick_in;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SEG_W-1:0] mk_seg(input int div, input bit v, input int idx,
                                                input bit b, input bit d, input int t);
        return {20'(div), v, 4'(idx), b, d, 8'(t)};
    endfunction

    // scoreboard: each time dut_a's output tuple changes, the finished segment
    // (tuple + tick_in rises seen during it) is compared to the expected queue
    always @(negedge clk) begin
        if (rec && (tup_a !== prev)) begin
            if (exp_q.size() == 0)
                check_eq("seg_extra", 64'(exp_q.size()), 64'd1);
            else
                check_eq("seg", {prev, 8'(seg_ticks)}, exp_q.pop_front());
            prev      = tup_a;
            seg_ticks = 0;
        end
        if (tick_in && !tick_last) seg_ticks++;
        tick_last = tick_in;
    end

    task automatic align_to_tick();
        @(posedge tick_in);
        repeat (10) @(negedge clk);
    endtask

    task automatic start_a();
        align_to_tick();
        play_a = 1'b1;
        @(negedge clk);
        play_a = 1'b0;
    endtask

    task automatic run_song_a(input bit toggle);
        int dones = 0;
        exp_q.push_back(mk_seg(0,     0, 0, 0, 0, 0));
        exp_q.push_back(mk_seg(45455, 1, 0, 1, 0, 2));
        exp_q.push_back(mk_seg(0,     0, 0, 1, 0, 1));
        exp_q.push_back(mk_seg(76336, 1, 1, 1, 0, 4));
        exp_q.push_back(mk_seg(0,     0, 1, 1, 0, 1));
        exp_q.push_back(mk_seg(0,     0, 2, 1, 0, 3));
        exp_q.push_back(mk_seg(0,     0, 3, 1, 0, 0));
        exp_q.push_back(mk_seg(0,     0, 3, 1, 1, 0));
        align_to_tick();
        prev      = tup_a;
        seg_ticks = 0;
        rec       = 1'b1;
        play_a    = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            play_a = (toggle && i < 30) ? (i % 3 != 0) : 1'b0;
            if (done_a) dones++;
        end
        rec = 1'b0;
        check_eq("a_done_count", 64'(dones), 64'd1);
        check_eq("a_segs_left", 64'(exp_q.size()), 64'd0);
        check_eq("a_end_idle", tup_a, '0);
        check_eq("a_end_state", state_a, ST_IDLE);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        int cnt;
        repeat (5) @(negedge clk);
        check_eq("rst_a", tup_a, '0);
        check_eq("rst_b", tup_b, '0);
        check_eq("rst_state", state_a, ST_IDLE);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

`ifndef MELODY_LOOP_EN
        run_song_a(1'b0);
        run_song_a(1'b1);
`else
        start_a();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (done_a) found = 1'b1;
        end
        check_eq("loop_a_done_seen", found, 1'b1);
        check_eq("loop_a_wrap", {note_idx_a, busy_a, note_valid_a, note_div_a}, {4'd0, 1'b1, 1'b1, 20'd45455});
        check_eq("loop_a_state", state_a, ST_NOTE);
        repeat (100) @(negedge clk);
        check_eq("loop_a_busy", busy_a, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("loop_a_stop", tup_a, '0);
`endif

        // stop in the middle of the C4 note
        start_a();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (note_div_a == 20'd76336) found = 1'b1;
        end
        check_eq("stop_c4_seen", found, 1'b1);
        repeat (20) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_outputs", tup_a, '0);
        check_eq("stop_state", state_a, ST_IDLE);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a || busy_a) cnt++;
        end
        check_eq("stop_quiet", 64'(cnt), 64'd0);

        // asynchronous reset mid-song, between clock edges
        start_a();
        repeat (100) @(negedge clk);
        check_eq("rst_mid_busy", busy_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_a", tup_a, '0);
        check_eq("rst_async_state", state_a, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_a || note_valid_a || busy_b || note_valid_b) cnt++;
        end
        check_eq("rst_quiet", 64'(cnt), 64'd0);

        // full 16-entry tune with play held high
        play_b = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (done_b) found = 1'b1;
        end
        check_eq("b_done_seen", found, 1'b1);
`ifndef MELODY_LOOP_EN
        check_eq("b_done_idx", note_idx_b, 4'd15);
        check_eq("b_done_out", {busy_b, note_valid_b, note_div_b}, {1'b1, 1'b0, 20'd0});
        check_eq("b_done_state", state_b, ST_DONE);
        @(negedge clk);
        check_eq("b_idle", tup_b, '0);
        @(negedge clk);
        check_eq("b_restart", tup_b, {20'd76336, 1'b1, 4'd0, 1'b1, 1'b0});
`else
        check_eq("loop_b_wrap", {note_idx_b, busy_b, note_div_b}, {4'd0, 1'b1, 20'd76336});
`endif
        play_b = 1'b0;
        stop   = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("b_stop", tup_b, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
